// File: rtl/store_buffer.sv
// Store buffer between MEM and the LSU. It queues retired stores and drains one
// per cycle whenever no load needs the single memory port.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_st_valid,
    input  logic [31:0] i_st_addr,
    input  logic [31:0] i_st_data,
    input  logic [2:0]  i_st_ctrl,
    output logic        o_st_ready,
    input  logic        i_ld_valid,
    input  logic [31:0] i_ld_addr,
    input  logic [2:0]  i_ld_ctrl,
    output logic        o_ld_stall,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_lsu_st_data,
    output logic        o_lsu_wren,
    output logic [2:0]  o_lsu_control,
    output logic        o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [2:0]    ctrl_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [DEPTH-1:0] entry_valid;
    logic             ld_conflict;
    logic             ld_issue;
    logic             push;
    logic             pop;

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        entry_valid = '0;
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, AW'(i) - head_q} < count_q);
            if (i_ld_valid && entry_valid[i] && (addr_q[i][31:2] == i_ld_addr[31:2]))
                ld_conflict = 1'b1;
        end
    end

    assign o_st_ready = (count_q < FULL_CNT);
    assign o_empty    = (count_q == '0);
    assign o_ld_stall = ld_conflict;

    assign ld_issue = i_ld_valid && !ld_conflict;
    assign push     = i_st_valid && o_st_ready;
    assign pop      = !ld_issue && (count_q != '0);

    // A non-conflicting load owns the port; otherwise the head store drains.
    always_comb begin
        o_lsu_addr    = 32'h0;
        o_lsu_st_data = 32'h0;
        o_lsu_wren    = 1'b0;
        o_lsu_control = 3'b000;
        if (ld_issue) begin
            o_lsu_addr    = i_ld_addr;
            o_lsu_control = i_ld_ctrl;
        end else if (pop) begin
            o_lsu_addr    = addr_q[head_q];
            o_lsu_st_data = data_q[head_q];
            o_lsu_control = ctrl_q[head_q];
            o_lsu_wren    = 1'b1;
        end
    end

    always_comb begin
        head_d  = pop  ? head_q + AW'(1) : head_q;
        tail_d  = push ? tail_q + AW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 32'h0;
                data_q[i] <= 32'h0;
                ctrl_q[i] <= 3'b000;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                addr_q[tail_q] <= i_st_addr;
                data_q[tail_q] <= i_st_data;
                ctrl_q[tail_q] <= i_st_ctrl;
            end
        end
    end

endmodule
